// File: rtl/core_rvfi_checker.sv
// ============================================================================
// core_rvfi_checker
// ----------------------------------------------------------------------------
// Passive RVFI (NRET = 1) consumer. Watches every retirement record the core
// puts on the RVFI bus and checks it against a shadow integer register file,
// PC continuity, x0 rules and memory byte-mask rules. A retirement watchdog
// flags a core that stops retiring. Never drives the core.
//
// Parameters
//   XLEN     data / PC width
//   ILEN     instruction width
//   TIMEOUT  idle cycles allowed between retirements (0 disables watchdog)
//
// Ports
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   rvfi_*                   one retirement record, qualified by rvfi_valid
//   err_clear                clears sticky flags and first-error capture
//   err_valid                one-cycle pulse, at least one new error
//   err_flags[5:0]           sticky flags:
//                              0 X0_RS  1 X0_RD  2 RS_MISMATCH
//                              3 PC_CONT 4 MEM_MASK 5 TIMEOUT
//   first_err_pc             pc_rdata (or expected PC on timeout) of the
//                            first erroring record
//   first_err_count          retirement index of the first erroring record
//   retired_count            number of records seen (wraps at 2^64)
// ============================================================================
module core_rvfi_checker #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              rvfi_valid,
  input  logic [ILEN-1:0]   rvfi_insn,
  input  logic              rvfi_intr,
  input  logic              rvfi_trap,
  input  logic [4:0]        rvfi_rs1_addr,
  input  logic [4:0]        rvfi_rs2_addr,
  input  logic [XLEN-1:0]   rvfi_rs1_rdata,
  input  logic [XLEN-1:0]   rvfi_rs2_rdata,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [XLEN-1:0]   rvfi_rd_wdata,
  input  logic [XLEN-1:0]   rvfi_pc_rdata,
  input  logic [XLEN-1:0]   rvfi_pc_wdata,
  input  logic [XLEN-1:0]   rvfi_mem_addr,
  input  logic [XLEN/8-1:0] rvfi_mem_rmask,
  input  logic [XLEN/8-1:0] rvfi_mem_wmask,
  input  logic              err_clear,
  output logic              err_valid,
  output logic [5:0]        err_flags,
  output logic [XLEN-1:0]   first_err_pc,
  output logic [63:0]       first_err_count,
  output logic [63:0]       retired_count
);

  localparam int          MW     = XLEN / 8;
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

  // Mask legality: no simultaneous read and write, only naturally sized
  // lane groups starting at lane 0, and address aligned to the access size.
  function automatic logic mem_bad(input logic [MW-1:0] rm,
                                   input logic [MW-1:0] wm,
                                   input logic [2:0]    a_lo);
    logic [MW-1:0] m;
    logic          bad;
    m   = rm | wm;
    bad = 1'b0;
    if ((rm != '0) && (wm != '0))  bad = 1'b1;
    else if (m == '0)              bad = 1'b0;
    else if (m == MW'(8'h01))      bad = 1'b0;
    else if (m == MW'(8'h03))      bad = a_lo[0];
    else if (m == MW'(8'h0F))      bad = (a_lo[1:0] != 2'b00);
    else if (m == MW'(8'hFF))      bad = (a_lo != 3'b000);
    else                           bad = 1'b1;
    return bad;
  endfunction

  // Architectural tracking state
  logic [XLEN-1:0] r_shadow [32];
  logic [31:0]     r_known;
  logic [XLEN-1:0] r_exp_pc;
  logic            r_pc_known;
  logic [31:0]     r_idle;
  logic            r_first_held;

  // Output registers
  logic            r_err_valid;
  logic [5:0]      r_err_flags;
  logic [XLEN-1:0] r_first_pc;
  logic [63:0]     r_first_cnt;
  logic [63:0]     r_retired;

  // Stage 0: combinational evaluation of the presented record
  logic            w_x0_rs_p0;
  logic            w_x0_rd_p0;
  logic            w_rs_mis_p0;
  logic            w_pc_p0;
  logic            w_mem_p0;
  logic            w_to_p0;
  logic [5:0]      w_e_p0;
  logic            w_any_p0;
  logic [XLEN-1:0] w_cap_pc_p0;
  logic            w_rd_wr_p0;
  logic            w_unused;

  assign w_unused = ^{rvfi_insn, rvfi_mem_addr[XLEN-1:3]};

  assign w_rd_wr_p0 = rvfi_valid && !rvfi_trap && (rvfi_rd_addr != 5'd0);

  assign w_x0_rs_p0 = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0)) ||
                      ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0));

  assign w_x0_rd_p0 = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);

  // Shadow read sees the value before this record's own write lands.
  assign w_rs_mis_p0 =
    ((rvfi_rs1_addr != 5'd0) && r_known[rvfi_rs1_addr] &&
     (rvfi_rs1_rdata != r_shadow[rvfi_rs1_addr])) ||
    ((rvfi_rs2_addr != 5'd0) && r_known[rvfi_rs2_addr] &&
     (rvfi_rs2_rdata != r_shadow[rvfi_rs2_addr]));

  assign w_pc_p0 = r_pc_known && !rvfi_intr && (rvfi_pc_rdata != r_exp_pc);

  assign w_mem_p0 = mem_bad(rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_addr[2:0]);

  // Fires only on the idle cycle that takes the counter up to the limit;
  // once saturated it stays quiet until a retirement re-arms it.
  assign w_to_p0 = (TO_LIM != 32'd0) && r_pc_known && !rvfi_valid &&
                   ((r_idle + 32'd1) == TO_LIM);

  assign w_e_p0 = {w_to_p0,
                   rvfi_valid & w_mem_p0,
                   rvfi_valid & w_pc_p0,
                   rvfi_valid & w_rs_mis_p0,
                   rvfi_valid & w_x0_rd_p0,
                   rvfi_valid & w_x0_rs_p0};

  assign w_any_p0    = (w_e_p0 != 6'd0);
  assign w_cap_pc_p0 = rvfi_valid ? rvfi_pc_rdata : r_exp_pc;

  // Stage 1: registered state and outputs
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_err_valid  <= 1'b0;
      r_err_flags  <= '0;
      r_first_pc   <= '0;
      r_first_cnt  <= '0;
      r_first_held <= 1'b0;
      r_retired    <= '0;
      r_known      <= '0;
      r_exp_pc     <= '0;
      r_pc_known   <= 1'b0;
      r_idle       <= '0;
    end else begin
      r_err_valid <= w_any_p0;
      r_err_flags <= (err_clear ? 6'd0 : r_err_flags) | w_e_p0;

      // A clear in the same cycle releases the held capture, so a new
      // error still gets recorded.
      if (w_any_p0 && (!r_first_held || err_clear)) begin
        r_first_pc   <= w_cap_pc_p0;
        r_first_cnt  <= r_retired;
        r_first_held <= 1'b1;
      end else if (err_clear) begin
        r_first_pc   <= '0;
        r_first_cnt  <= '0;
        r_first_held <= 1'b0;
      end

      if (rvfi_valid) begin
        r_retired  <= r_retired + 64'd1;
        r_exp_pc   <= rvfi_pc_wdata;
        r_pc_known <= 1'b1;
        r_idle     <= '0;
      end else if (r_pc_known && (TO_LIM != 32'd0) && (r_idle != TO_LIM)) begin
        r_idle <= r_idle + 32'd1;
      end

      if (w_rd_wr_p0) begin
        r_known[rvfi_rd_addr] <= 1'b1;
      end
    end
  end

  // Shadow data carries no reset; validity lives in r_known.
  always_ff @(posedge g_clk) begin
    if (w_rd_wr_p0) begin
      r_shadow[rvfi_rd_addr] <= rvfi_rd_wdata;
    end
  end

  assign err_valid       = r_err_valid;
  assign err_flags       = r_err_flags;
  assign first_err_pc    = r_first_pc;
  assign first_err_count = r_first_cnt;
  assign retired_count   = r_retired;

endmodule

// File: tb/tb_core_rvfi_checker.sv
module tb_core_rvfi_checker;

  localparam int XLEN = 64;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv, intr, trap, clr;
  logic [31:0] insn;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] rs1d, rs2d, rdd, pcr, pcw, maddr;
  logic [7:0]  rmask, wmask;

  logic        o_ev;
  logic [5:0]  o_flags;
  logic [63:0] o_fpc, o_fcnt, o_ret;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [63:0] m_sh [32];
  bit          m_kn [32];
  logic [63:0] m_epc;
  bit          m_pck;
  logic [63:0] m_ret;
  int          m_idle;
  bit          m_held;
  logic        m_ev;
  logic [5:0]  m_flags;
  logic [63:0] m_fpc, m_fcnt;

  core_rvfi_checker #(.XLEN(XLEN), .ILEN(32), .TIMEOUT(TO)) dut (
    .g_clk(clk), .g_resetn(rst_n), .rvfi_valid(rv), .rvfi_insn(insn),
    .rvfi_intr(intr), .rvfi_trap(trap),
    .rvfi_rs1_addr(rs1), .rvfi_rs2_addr(rs2),
    .rvfi_rs1_rdata(rs1d), .rvfi_rs2_rdata(rs2d),
    .rvfi_rd_addr(rd), .rvfi_rd_wdata(rdd),
    .rvfi_pc_rdata(pcr), .rvfi_pc_wdata(pcw),
    .rvfi_mem_addr(maddr), .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
    .err_clear(clr), .err_valid(o_ev), .err_flags(o_flags),
    .first_err_pc(o_fpc), .first_err_count(o_fcnt), .retired_count(o_ret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit mem_illegal(input logic [7:0] r, input logic [7:0] w,
                                     input logic [63:0] a);
    logic [7:0] m;
    int n;
    if (r != 0 && w != 0) return 1'b1;
    m = r | w;
    if (m == 0) return 1'b0;
    n = $countones(m);
    if (!(n inside {1, 2, 4, 8})) return 1'b1;
    if (m != 8'((1 << n) - 1)) return 1'b1;
    return (a % n) != 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_kn[i] = 1'b0;
    m_epc = '0; m_pck = 1'b0; m_ret = '0; m_idle = 0; m_held = 1'b0;
    m_ev = 1'b0; m_flags = '0; m_fpc = '0; m_fcnt = '0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_err_valid"}, 64'(o_ev), 64'(m_ev));
    chk({pfx, "_err_flags"}, 64'(o_flags), 64'(m_flags));
    chk({pfx, "_first_pc"}, o_fpc, m_fpc);
    chk({pfx, "_first_cnt"}, o_fcnt, m_fcnt);
    chk({pfx, "_retired"}, o_ret, m_ret);
  endtask

  // Apply current inputs for one cycle, predict, then compare after the edge.
  task automatic step();
    logic [5:0] e;
    e = '0;
    if (rv) begin
      if ((rs1 == 0 && rs1d != 0) || (rs2 == 0 && rs2d != 0)) e[0] = 1'b1;
      if (rd == 0 && rdd != 0) e[1] = 1'b1;
      if ((rs1 != 0 && m_kn[rs1] && m_sh[rs1] != rs1d) ||
          (rs2 != 0 && m_kn[rs2] && m_sh[rs2] != rs2d)) e[2] = 1'b1;
      if (m_pck && !intr && pcr != m_epc) e[3] = 1'b1;
      if (mem_illegal(rmask, wmask, maddr)) e[4] = 1'b1;
    end else if (m_pck && m_idle < TO) begin
      m_idle++;
      if (m_idle == TO) e[5] = 1'b1;
    end
    m_ev    = (e != 0);
    m_flags = clr ? e : (m_flags | e);
    if (e != 0 && (!m_held || clr)) begin
      m_fpc  = rv ? pcr : m_epc;
      m_fcnt = m_ret;
      m_held = 1'b1;
    end else if (clr) begin
      m_fpc = '0; m_fcnt = '0; m_held = 1'b0;
    end
    if (rv) begin
      m_ret  = m_ret + 1;
      m_epc  = pcw;
      m_pck  = 1'b1;
      m_idle = 0;
      if (!trap && rd != 0) begin
        m_sh[rd] = rdd;
        m_kn[rd] = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_outputs("cyc");
  endtask

  // Default: no record; PC fields set to continue the tracked stream.
  task automatic clear_in();
    rv = 0; intr = 0; trap = 0; clr = 0; insn = '0;
    rs1 = 0; rs2 = 0; rd = 0; rs1d = 0; rs2d = 0; rdd = 0;
    maddr = 0; rmask = 0; wmask = 0;
    pcr = m_pck ? m_epc : 64'h1000;
    pcw = pcr + 4;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs("rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_in();
  endtask

  initial begin
    logic [7:0] legal [4];
    legal[0] = 8'h01; legal[1] = 8'h03; legal[2] = 8'h0F; legal[3] = 8'hFF;
    model_reset();
    clear_in();
    #12;
    do_reset();

    // Dependent pair, clean
    clear_in(); rv = 1; rd = 5; rdd = 64'h10; step();
    clear_in(); rv = 1; rs1 = 5; rs2 = 5; rs1d = 64'h10; rs2d = 64'h10;
    rd = 6; rdd = 64'h20; step();
    chk("tp1_flags", 64'(o_flags), 64'h0);
    chk("tp1_retired", o_ret, 64'd2);

    // Dependent pair, stale source value
    do_reset();
    clear_in(); rv = 1; rd = 5; rdd = 64'h10; step();
    clear_in(); rv = 1; rs1 = 5; rs1d = 64'h11; rd = 6; rdd = 64'h21; step();
    chk("tp2_valid", 64'(o_ev), 64'h1);
    chk("tp2_flags", 64'(o_flags), 64'h04);
    chk("tp2_fcnt", o_fcnt, 64'd1);
    clear_in(); step();
    chk("tp2_pulse_end", 64'(o_ev), 64'h0);

    // PC discontinuity, then the same jump entering a trap handler
    do_reset();
    clear_in(); rv = 1; pcr = 64'h1000; pcw = 64'h1004; step();
    clear_in(); rv = 1; pcr = 64'h1008; pcw = 64'h100C; step();
    chk("tp3_pc_flags", 64'(o_flags), 64'h08);
    chk("tp3_pc_fpc", o_fpc, 64'h1008);
    do_reset();
    clear_in(); rv = 1; pcr = 64'h1000; pcw = 64'h1004; step();
    clear_in(); rv = 1; intr = 1; pcr = 64'h1008; pcw = 64'h100C; step();
    chk("tp3_intr_flags", 64'(o_flags), 64'h0);

    // Both x0 rules in one record
    do_reset();
    clear_in(); rv = 1; rd = 0; rdd = 5; rs2 = 0; rs2d = 1; step();
    chk("tp4_flags", 64'(o_flags), 64'h03);
    chk("tp4_valid", 64'(o_ev), 64'h1);

    // Memory masks
    do_reset();
    clear_in(); rv = 1; maddr = 64'h1002; rmask = 8'h0F; step();
    chk("tp5_misalign", 64'(o_flags), 64'h10);
    clear_in(); rv = 1; clr = 1; maddr = 64'h1004; rmask = 8'h0F; step();
    chk("tp5_aligned", 64'(o_flags), 64'h0);
    clear_in(); rv = 1; maddr = 64'h1004; rmask = 8'h01; wmask = 8'h01; step();
    chk("tp5_rw", 64'(o_flags), 64'h10);

    // Watchdog, then clear racing a new error
    do_reset();
    clear_in(); rv = 1; step();
    for (int i = 0; i < TO - 1; i++) begin clear_in(); step(); end
    chk("tp6_before", 64'(o_flags), 64'h0);
    clear_in(); step();
    chk("tp6_to_flags", 64'(o_flags), 64'h20);
    chk("tp6_to_valid", 64'(o_ev), 64'h1);
    chk("tp6_to_fpc", o_fpc, 64'h1004);
    chk("tp6_to_fcnt", o_fcnt, 64'd1);
    for (int i = 0; i < 4; i++) begin
      clear_in(); step();
      chk("tp6_single_pulse", 64'(o_ev), 64'h0);
    end
    clear_in(); rv = 1; clr = 1; rd = 0; rdd = 7; step();
    chk("tp6_clr_flags", 64'(o_flags), 64'h02);
    chk("tp6_clr_fpc", o_fpc, 64'h1004);
    chk("tp6_clr_fcnt", o_fcnt, 64'd1);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 900; n++) begin
      if (n == 450) do_reset();
      clear_in();
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) begin
        for (int k = $urandom_range(6, 12); k > 0; k--) begin
          clear_in(); step();
        end
        clear_in();
      end
      if ($urandom_range(0, 9) < 7) begin
        rv   = 1;
        insn = $urandom;
        intr = ($urandom_range(0, 19) == 0);
        trap = ($urandom_range(0, 9) == 0);
        rs1  = 5'($urandom_range(0, 4));
        rs2  = 5'($urandom_range(0, 4));
        rd   = 5'($urandom_range(0, 4));
        rs1d = (rs1 != 0 && m_kn[rs1]) ? m_sh[rs1] : ((rs1 == 0) ? 64'h0 : {$urandom, $urandom});
        rs2d = (rs2 != 0 && m_kn[rs2]) ? m_sh[rs2] : ((rs2 == 0) ? 64'h0 : {$urandom, $urandom});
        if ($urandom_range(0, 9) == 0) rs1d = rs1d ^ 64'(1 << $urandom_range(0, 3));
        if ($urandom_range(0, 14) == 0) rs2d = rs2d + 1;
        rdd  = (rd == 0 && $urandom_range(0, 9) != 0) ? 64'h0 : {$urandom, $urandom};
        if ($urandom_range(0, 9) == 0) pcr = pcr + 8;
        pcw  = ($urandom_range(0, 7) == 0) ? {32'h0, $urandom & 32'hFFFF_FFFC} : pcr + 4;
        maddr = {$urandom, $urandom} & ~64'h7;
        case ($urandom_range(0, 9))
          5, 9: rmask = legal[$urandom_range(0, 3)];
          6: begin wmask = legal[$urandom_range(0, 3)]; maddr[2:0] = 3'($urandom_range(0, 7)); end
          7: begin rmask = legal[$urandom_range(0, 3)]; wmask = legal[$urandom_range(0, 3)]; end
          8: rmask = 8'($urandom);
          default: ;
        endcase
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
